// File: rtl/datamem_sync.sv
// Byte-addressed synchronous data memory with a valid/ready request port and a
// single registered response slot (1-cycle latency, back-to-back capable).
module datamem_sync #(
   parameter int unsigned MEM_BYTES  = 65536,
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned DATA_BYTES = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [2:0]              req_size,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic [8*DATA_BYTES-1:0] req_wdata,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [8*DATA_BYTES-1:0] resp_rdata,
   output logic                    resp_err
);

   localparam int unsigned DW    = 8 * DATA_BYTES;
   localparam int unsigned EXT_W = ADDR_W + 4;
   localparam int unsigned MA_W  = $clog2(MEM_BYTES);

   logic [7:0]            r_mem [MEM_BYTES];
   logic                  r_resp_valid;
   logic                  r_resp_err;
   logic [DW-1:0]         r_resp_rdata;

   logic                  w_accept;
   logic                  w_err;
   logic                  w_wr_en;
   logic [EXT_W-1:0]      w_addr_ext;
   logic [EXT_W-1:0]      w_nbytes;
   logic [DATA_BYTES-1:0] w_lane_en;
   logic [DW-1:0]         w_rdata;

   assign req_ready  = !r_resp_valid || resp_ready;
   assign resp_valid = r_resp_valid;
   assign resp_err   = r_resp_err;
   assign resp_rdata = r_resp_rdata;

   // Request decode: widened address arithmetic so the bound check never wraps.
   always_comb begin
      w_addr_ext = EXT_W'(req_addr);
      w_nbytes   = EXT_W'(1) << req_size;
      w_err      = (req_size > 3'd3)
                || (w_nbytes > EXT_W'(DATA_BYTES))
                || ((w_addr_ext & (w_nbytes - EXT_W'(1))) != '0)
                || ((w_addr_ext + w_nbytes) > EXT_W'(MEM_BYTES));
      w_accept   = req_valid && req_ready && !reset;
      w_wr_en    = w_accept && req_write && !w_err;
      w_lane_en  = '0;
      w_rdata    = '0;
      for (int i = 0; i < int'(DATA_BYTES); i++) begin
         w_lane_en[i] = EXT_W'(i) < w_nbytes;
      end
      if (!req_write && !w_err) begin
         for (int i = 0; i < int'(DATA_BYTES); i++) begin
            if (w_lane_en[i]) begin
               w_rdata[8*i +: 8] = r_mem[MA_W'(w_addr_ext + EXT_W'(i))];
            end
         end
      end
   end

   // Storage is never reset; only enabled lanes of an error-free write change.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int i = 0; i < int'(DATA_BYTES); i++) begin
            if (w_lane_en[i]) begin
               r_mem[MA_W'(w_addr_ext + EXT_W'(i))] <= req_wdata[8*i +: 8];
            end
         end
      end
   end

   // Response slot: a new accept overwrites (retire+load), else drain on ready.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
      end else if (w_accept) begin
         r_resp_valid <= 1'b1;
         r_resp_err   <= w_err;
         r_resp_rdata <= w_rdata;
      end else if (resp_ready) begin
         r_resp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_datamem_sync.sv
// Self-checking bench for datamem_sync: directed scenarios plus a randomized
// run scored against a byte-array reference model.
module tb_datamem_sync;

   localparam int unsigned MEM_BYTES  = 65536;
   localparam int unsigned ADDR_W     = 16;
   localparam int unsigned DATA_BYTES = 2;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_size;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] resp_rdata;
   logic        resp_err;

   int errors = 0;
   int checks = 0;

   logic [7:0] m_mem   [MEM_BYTES];
   bit         m_known [MEM_BYTES];

   typedef struct {
      logic [15:0] d;
      logic [15:0] m;
      logic        e;
   } exp_t;
   exp_t q[$];

   datamem_sync #(
      .MEM_BYTES (MEM_BYTES),
      .ADDR_W    (ADDR_W),
      .DATA_BYTES(DATA_BYTES)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_size  (req_size),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_rdata(resp_rdata),
      .resp_err  (resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1);
   end

   function automatic bit model_err(input logic [2:0] sz, input logic [15:0] a);
      int nb = 1 << sz;
      return (sz > 3) || (nb > int'(DATA_BYTES)) || ((int'(a) % nb) != 0)
          || (int'(a) + nb > int'(MEM_BYTES));
   endfunction

   task automatic model_accept(input logic w, input logic [2:0] sz,
                               input logic [15:0] a, input logic [15:0] d);
      if (w && !model_err(sz, a)) begin
         for (int i = 0; i < (1 << sz); i++) begin
            m_mem[int'(a) + i]   = d[8*i +: 8];
            m_known[int'(a) + i] = 1'b1;
         end
      end
   endtask

   // Present one request with resp_ready high; returns 1 ns after the accept edge.
   task automatic send(input logic w, input logic [2:0] sz,
                       input logic [15:0] a, input logic [15:0] d);
      int n = 0;
      req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = d;
      resp_ready = 1'b1;
      @(negedge clk);
      while (!req_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_accept: req_ready=%b required 1", req_ready);
      end
      model_accept(w, sz, a, d);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_size = 3'd1;
      req_addr = 16'h0040; req_wdata = 16'h1234; resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 16'h0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b err=%b rdata=%h required 0 0 0000",
                  resp_valid, resp_err, resp_rdata);
      end
      reset = 1'b0; req_valid = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_req_ready: req_ready=%b required 1", req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_accept: resp_valid=%b required 0", resp_valid);
      end
   endtask

   task automatic test_basic;
      send(1'b1, 3'd1, 16'h0010, 16'hBEEF);
      checks++;
      if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 16'h0) begin
         errors++;
         $display("FAIL basic_write_resp: valid=%b err=%b rdata=%h required 1 0 0000",
                  resp_valid, resp_err, resp_rdata);
      end
      send(1'b0, 3'd1, 16'h0010, 16'h0);
      checks++;
      if (resp_err !== 1'b0 || resp_rdata !== 16'hBEEF) begin
         errors++;
         $display("FAIL basic_read16: err=%b rdata=%h required 0 beef", resp_err, resp_rdata);
      end
      send(1'b0, 3'd0, 16'h0011, 16'h0);
      checks++;
      if (resp_err !== 1'b0 || resp_rdata !== 16'h00BE) begin
         errors++;
         $display("FAIL basic_read8_hi: err=%b rdata=%h required 0 00be", resp_err, resp_rdata);
      end
      send(1'b0, 3'd0, 16'h0010, 16'h0);
      checks++;
      if (resp_rdata !== 16'h00EF) begin
         errors++;
         $display("FAIL basic_read8_lo: rdata=%h required 00ef", resp_rdata);
      end
   endtask

   task automatic test_errors;
      send(1'b1, 3'd1, 16'h0002, 16'h7766);
      send(1'b1, 3'd1, 16'h0003, 16'h1234);
      checks++;
      if (resp_err !== 1'b1 || resp_rdata !== 16'h0) begin
         errors++;
         $display("FAIL err_misaligned_write: err=%b rdata=%h required 1 0000", resp_err, resp_rdata);
      end
      send(1'b0, 3'd0, 16'h0003, 16'h0);
      checks++;
      if (resp_err !== 1'b0 || resp_rdata !== 16'h0077) begin
         errors++;
         $display("FAIL err_mem_unchanged: err=%b rdata=%h required 0 0077", resp_err, resp_rdata);
      end
      send(1'b0, 3'd2, 16'h0000, 16'h0);
      checks++;
      if (resp_err !== 1'b1 || resp_rdata !== 16'h0) begin
         errors++;
         $display("FAIL err_too_wide: err=%b rdata=%h required 1 0000", resp_err, resp_rdata);
      end
      send(1'b0, 3'd5, 16'h0000, 16'h0);
      checks++;
      if (resp_err !== 1'b1) begin
         errors++;
         $display("FAIL err_size_gt3: err=%b required 1", resp_err);
      end
      send(1'b0, 3'd1, 16'h0011, 16'h0);
      checks++;
      if (resp_err !== 1'b1 || resp_rdata !== 16'h0) begin
         errors++;
         $display("FAIL err_misaligned_read: err=%b rdata=%h required 1 0000", resp_err, resp_rdata);
      end
      send(1'b1, 3'd1, 16'hFFFE, 16'h1234);
      send(1'b1, 3'd0, 16'hFFFF, 16'h005A);
      send(1'b0, 3'd0, 16'hFFFF, 16'h0);
      checks++;
      if (resp_err !== 1'b0 || resp_rdata !== 16'h005A) begin
         errors++;
         $display("FAIL top_byte: err=%b rdata=%h required 0 005a", resp_err, resp_rdata);
      end
      send(1'b0, 3'd1, 16'hFFFE, 16'h0);
      checks++;
      if (resp_err !== 1'b0 || resp_rdata !== 16'h5A34) begin
         errors++;
         $display("FAIL top_half: err=%b rdata=%h required 0 5a34", resp_err, resp_rdata);
      end
   endtask

   task automatic test_back_to_back;
      send(1'b1, 3'd1, 16'h0020, 16'hC0DE);
      send(1'b0, 3'd1, 16'h0020, 16'h0);
      checks++;
      if (resp_rdata !== 16'hC0DE) begin
         errors++;
         $display("FAIL raw_next_edge: rdata=%h required c0de", resp_rdata);
      end
      send(1'b1, 3'd0, 16'h0021, 16'h0011);
      send(1'b0, 3'd1, 16'h0020, 16'h0);
      checks++;
      if (resp_rdata !== 16'h11DE) begin
         errors++;
         $display("FAIL raw_byte_merge: rdata=%h required 11de", resp_rdata);
      end
   endtask

   task automatic test_stall;
      send(1'b0, 3'd1, 16'h0010, 16'h0);
      resp_ready = 1'b0;
      req_valid = 1'b1; req_write = 1'b0; req_size = 3'd0; req_addr = 16'h0011;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== 16'hBEEF
             || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: cyc=%0d ready=%b valid=%b rdata=%h err=%b required 0 1 beef 0",
                     k, req_ready, resp_valid, resp_rdata, resp_err);
         end
         @(posedge clk);
      end
      #1;
      resp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall_release_ready: req_ready=%b required 1", req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 16'h00BE) begin
         errors++;
         $display("FAIL stall_next_resp: valid=%b rdata=%h required 1 00be", resp_valid, resp_rdata);
      end
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL retire_idle: resp_valid=%b required 0", resp_valid);
      end
   endtask

   task automatic test_reset_inflight;
      send(1'b0, 3'd1, 16'h0010, 16'h0);
      resp_ready = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if (resp_valid !== 1'b0 || resp_rdata !== 16'h0 || resp_err !== 1'b0) begin
         errors++;
         $display("FAIL inflight_reset: valid=%b rdata=%h err=%b required 0 0000 0",
                  resp_valid, resp_rdata, resp_err);
      end
      send(1'b0, 3'd0, 16'h0010, 16'h0);
      checks++;
      if (resp_rdata !== 16'h00EF || resp_err !== 1'b0) begin
         errors++;
         $display("FAIL mem_survives_reset: rdata=%h err=%b required 00ef 0", resp_rdata, resp_err);
      end
   endtask

   task automatic test_random;
      resp_ready = 1'b1; req_valid = 1'b0;
      @(posedge clk); #1;
      for (int n = 0; n < 10003; n++) begin
         if (n < 10000) begin
            req_valid  = ($urandom_range(3) != 0);
            req_write  = $urandom_range(1);
            req_size   = ($urandom_range(9) < 8) ? 3'($urandom_range(2)) : 3'($urandom_range(7));
            req_addr   = $urandom_range(1) ? 16'($urandom_range(63))
                                           : 16'(16'hFFC0 + $urandom_range(63));
            req_wdata  = 16'($urandom);
            resp_ready = ($urandom_range(2) != 0);
         end else begin
            req_valid = 1'b0; resp_ready = 1'b1;
         end
         @(negedge clk);
         if (resp_valid) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL rand_spurious: cyc=%0d resp_valid=1 with nothing outstanding", n);
            end else if ((((resp_rdata ^ q[0].d) & q[0].m) !== 16'h0) || resp_err !== q[0].e) begin
               errors++;
               $display("FAIL rand_resp: cyc=%0d rdata=%h err=%b required %h err=%b mask=%h",
                        n, resp_rdata, resp_err, q[0].d, q[0].e, q[0].m);
            end
            if (resp_ready && q.size() != 0) void'(q.pop_front());
         end
         checks++;
         if (req_ready !== (!resp_valid || resp_ready)) begin
            errors++;
            $display("FAIL rand_req_ready: cyc=%0d req_ready=%b required %b",
                     n, req_ready, (!resp_valid || resp_ready));
         end
         if (req_valid && req_ready) begin
            exp_t x;
            x.e = model_err(req_size, req_addr);
            x.d = 16'h0;
            x.m = 16'hFFFF;
            if (!req_write && !x.e) begin
               for (int i = 0; i < (1 << req_size); i++) begin
                  if (m_known[int'(req_addr) + i]) x.d[8*i +: 8] = m_mem[int'(req_addr) + i];
                  else                             x.m[8*i +: 8] = 8'h00;
               end
            end
            q.push_back(x);
            model_accept(req_write, req_size, req_addr, req_wdata);
         end
         @(posedge clk); #1;
      end
      checks++;
      if (q.size() != 0 || resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rand_drain: outstanding=%0d resp_valid=%b required 0 0", q.size(), resp_valid);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_errors;
      test_back_to_back;
      test_stall;
      test_reset_inflight;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
